// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX forwarding selects, load-use and MD-unit stalls, MD scoreboard.
// Optional saturating stall-cycle counter enabled by defining HAZARD_PERF_EN.
`timescale 1ns/1ps
module hazard_ctrl_unit #(
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [NRD*AW-1:0]  id_rs,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_regwrite,
  input  logic               id_md,
  input  logic [NRD*AW-1:0]  ex_rs,
  input  logic [AW-1:0]      ex_rd,
  input  logic               ex_memread,
  input  logic               ex_md_start,
  input  logic [AW-1:0]      mem_rd,
  input  logic               mem_regwrite,
  input  logic [AW-1:0]      wb_rd,
  input  logic               wb_regwrite,
  output logic [2*NRD-1:0]   fwd_sel,
  output logic               stall,
  output logic               flush_ex,
  output logic               md_busy,
  output logic               md_done,
  output logic [AW-1:0]      md_rd,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int CW = ($clog2(MD_LAT) > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 2);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   md_rd_q, md_rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      md_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_rd_q <= md_rd_d;
    end
  end

  // A new ex_md_start is only accepted from IDLE; outside IDLE it is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;
    case (state_q)
      S_IDLE: begin
        if (ex_md_start) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
          md_rd_d = ex_rd;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign md_busy = (state_q != S_IDLE);
  assign md_done = (state_q == S_DONE);
  assign md_rd   = md_rd_q;

  // Pending MD destination: the issuing op in its issue cycle, the captured one afterwards.
  logic [AW-1:0] p_rd;
  logic          p_valid;
  assign p_rd    = (state_q == S_IDLE) ? ex_rd : md_rd_q;
  assign p_valid = ((state_q == S_IDLE) ? ex_md_start : 1'b1) && (p_rd != '0);

  logic load_use_hit, md_raw_hit;
  always_comb begin
    load_use_hit = 1'b0;
    md_raw_hit   = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (id_rs[i*AW +: AW] == ex_rd) load_use_hit = 1'b1;
      if (p_valid && (id_rs[i*AW +: AW] == p_rd)) md_raw_hit = 1'b1;
    end
  end

  logic load_use, md_waw, md_struct;
  assign load_use  = ex_memread && (ex_rd != '0) && load_use_hit;
  assign md_waw    = id_regwrite && (id_rd != '0) && p_valid && (id_rd == p_rd);
  assign md_struct = id_md && ((state_q != S_IDLE) || ex_md_start);

  assign stall    = id_valid && (load_use || md_raw_hit || md_waw || md_struct);
  assign flush_ex = stall;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_fwd
      logic [AW-1:0] rs;
      logic [1:0]    sel;
      assign rs = ex_rs[gi*AW +: AW];
      always_comb begin
        sel = 2'b00;
        if (rs == '0)                             sel = 2'b00;
        else if (mem_regwrite && (mem_rd == rs))  sel = 2'b10;
        else if (wb_regwrite && (wb_rd == rs))    sel = 2'b01;
        else if (md_done && (md_rd_q == rs))      sel = 2'b11;
      end
      assign fwd_sel[gi*2 +: 2] = sel;
    end
  endgenerate

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (stall && !(&stall_cycles_q)) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end
  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
